// File: rtl/camera_update_sequencer.sv
// camera_update_sequencer
// Collects a nine-word camera basis (right, up, forward) into a shadow bank
// and copies it to the renderer-facing active bank only on a frame-start
// pulse. Because of this, the renderer never sees a half-updated basis.
module camera_update_sequencer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 9
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          new_frame_in,
  input  logic                          upd_valid_in,
  output logic                          upd_ready_out,
  input  logic [3:0]                    upd_idx_in,
  input  logic [WORD_W-1:0]             upd_data_in,
  input  logic                          upd_last_in,
  output logic [NUM_WORDS*WORD_W-1:0]   cam_out,
  output logic                          cam_valid_out,
  output logic                          commit_out,
  output logic                          pending_out,
  output logic                          err_out,
  output logic [7:0]                    frames_since_commit_out
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [4:0] NUM_WORDS_U = 5'(NUM_WORDS);

  state_t                              state_q, state_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]    shadow_q, shadow_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0]    active_q, active_d;
  logic [NUM_WORDS-1:0]                mask_q, mask_d;
  logic                                cam_valid_q, cam_valid_d;
  logic                                commit_q, commit_d;
  logic                                err_q, err_d;
  logic [7:0]                          frames_q, frames_d;

  // Helpers for the word currently on the update port.
  logic                                idx_ok;
  logic [NUM_WORDS-1:0]                wr_mask;
  logic [NUM_WORDS-1:0]                mask_with_word;

  assign idx_ok         = ({1'b0, upd_idx_in} < NUM_WORDS_U);
  assign wr_mask        = idx_ok ? (NUM_WORDS'(1) << upd_idx_in) : '0;
  assign mask_with_word = mask_q | wr_mask;

  // Next-state logic: word capture in IDLE, commit on the frame in PENDING.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    mask_d      = mask_q;
    cam_valid_d = cam_valid_q;
    commit_d    = 1'b0;
    err_d       = 1'b0;
    frames_d    = frames_q;

    // Every frame pulse counts; a commit below overrides this with zero.
    if (new_frame_in) begin
      frames_d = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (upd_valid_in) begin
          if (idx_ok) begin
            shadow_d[upd_idx_in] = upd_data_in;
            mask_d               = mask_with_word;
          end else begin
            err_d = 1'b1;
          end
          // The set is judged on the mask even if this word itself was bad.
          if (upd_last_in) begin
            if (&mask_with_word) begin
              state_d = ST_PENDING;
            end else begin
              err_d  = 1'b1;
              mask_d = '0;
            end
          end
        end
      end
      ST_PENDING: begin
        if (new_frame_in) begin
          active_d    = shadow_q;
          commit_d    = 1'b1;
          cam_valid_d = 1'b1;
          mask_d      = '0;
          frames_d    = 8'd0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bank registers; reset wipes partial, pending and active sets.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      active_q    <= '0;
      mask_q      <= '0;
      cam_valid_q <= 1'b0;
      commit_q    <= 1'b0;
      err_q       <= 1'b0;
      frames_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      mask_q      <= mask_d;
      cam_valid_q <= cam_valid_d;
      commit_q    <= commit_d;
      err_q       <= err_d;
      frames_q    <= frames_d;
    end
  end

  // Word i of the packed active bank lands at bits [i*WORD_W +: WORD_W].
  assign cam_out                 = active_q;
  assign upd_ready_out           = (state_q == ST_IDLE);
  assign pending_out             = (state_q == ST_PENDING);
  assign cam_valid_out           = cam_valid_q;
  assign commit_out              = commit_q;
  assign err_out                 = err_q;
  assign frames_since_commit_out = frames_q;

endmodule

// File: tb/tb_camera_update_sequencer.sv
// Directed bench for camera_update_sequencer.
module tb_camera_update_sequencer;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 9;

  logic                        clk_in;
  logic                        rst_n_in;
  logic                        new_frame_in;
  logic                        upd_valid_in;
  logic                        upd_ready_out;
  logic [3:0]                  upd_idx_in;
  logic [WORD_W-1:0]           upd_data_in;
  logic                        upd_last_in;
  logic [NUM_WORDS*WORD_W-1:0] cam_out;
  logic                        cam_valid_out;
  logic                        commit_out;
  logic                        pending_out;
  logic                        err_out;
  logic [7:0]                  frames_since_commit_out;

  int tests;
  int failed;

  camera_update_sequencer #(
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .clk_in                  (clk_in),
    .rst_n_in                (rst_n_in),
    .new_frame_in            (new_frame_in),
    .upd_valid_in            (upd_valid_in),
    .upd_ready_out           (upd_ready_out),
    .upd_idx_in              (upd_idx_in),
    .upd_data_in             (upd_data_in),
    .upd_last_in             (upd_last_in),
    .cam_out                 (cam_out),
    .cam_valid_out           (cam_valid_out),
    .commit_out              (commit_out),
    .pending_out             (pending_out),
    .err_out                 (err_out),
    .frames_since_commit_out (frames_since_commit_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] cam_word(input int i);
    return cam_out[i*WORD_W +: WORD_W];
  endfunction

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Present one word (optionally with a frame pulse) for a single cycle.
  task automatic send_word(input int idx, input logic [WORD_W-1:0] data,
                           input logic last, input logic frame);
    upd_valid_in = 1'b1;
    upd_idx_in   = 4'(idx);
    upd_data_in  = data;
    upd_last_in  = last;
    new_frame_in = frame;
    step();
    upd_valid_in = 1'b0;
    upd_last_in  = 1'b0;
    new_frame_in = 1'b0;
    $display("[TB] word idx=%0d data=0x%0h last=%0b frame=%0b -> ready=%0b pending=%0b err=%0b commit=%0b frames=%0d",
             idx, data, last, frame, upd_ready_out, pending_out, err_out, commit_out,
             frames_since_commit_out);
  endtask

  task automatic frame_pulse();
    new_frame_in = 1'b1;
    step();
    new_frame_in = 1'b0;
    $display("[TB] frame -> commit=%0b pending=%0b frames=%0d cam_valid=%0b",
             commit_out, pending_out, frames_since_commit_out, cam_valid_out);
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    rst_n_in     = 1'b0;
    new_frame_in = 1'b0;
    upd_valid_in = 1'b0;
    upd_idx_in   = 4'd0;
    upd_data_in  = '0;
    upd_last_in  = 1'b0;

    // Reset state
    #2;
    chk("rst_ready",     64'(upd_ready_out), 64'd1);
    chk("rst_pending",   64'(pending_out), 64'd0);
    chk("rst_cam_valid", 64'(cam_valid_out), 64'd0);
    chk("rst_commit",    64'(commit_out), 64'd0);
    chk("rst_err",       64'(err_out), 64'd0);
    chk("rst_frames",    64'(frames_since_commit_out), 64'd0);
    chk("rst_cam",       64'(cam_out == '0), 64'd1);
    step();
    step();
    rst_n_in = 1'b1;
    step();

    // Clean set 0x100+i, frame 5 cycles after the last word
    for (int i = 0; i < NUM_WORDS; i++) begin
      send_word(i, 32'h100 + 32'(i), (i == NUM_WORDS - 1), 1'b0);
      if (i == 0) chk("clean_not_pending_early", 64'(pending_out), 64'd0);
    end
    chk("clean_pending", 64'(pending_out), 64'd1);
    chk("clean_ready_low", 64'(upd_ready_out), 64'd0);
    chk("clean_no_err", 64'(err_out), 64'd0);
    repeat (4) step();
    chk("clean_no_commit_yet", 64'(commit_out), 64'd0);
    frame_pulse();
    chk("clean_commit", 64'(commit_out), 64'd1);
    chk("clean_pending_clear", 64'(pending_out), 64'd0);
    chk("clean_ready_back", 64'(upd_ready_out), 64'd1);
    chk("clean_cam_valid", 64'(cam_valid_out), 64'd1);
    chk("clean_frames_zero", 64'(frames_since_commit_out), 64'd0);
    for (int i = 0; i < NUM_WORDS; i++)
      chk($sformatf("clean_word%0d", i), 64'(cam_word(i)), 64'h100 + 64'(i));
    step();
    chk("clean_commit_width1", 64'(commit_out), 64'd0);

    // Tear guard: set B queued, extra valids while pending are ignored
    for (int i = 0; i < NUM_WORDS; i++)
      send_word(i, 32'h200 + 32'(i), (i == NUM_WORDS - 1), 1'b0);
    chk("tear_pending", 64'(pending_out), 64'd1);
    for (int k = 0; k < 3; k++) begin
      send_word(k, 32'hDEAD, 1'b1, 1'b0);
      chk("tear_ready_low", 64'(upd_ready_out), 64'd0);
      chk("tear_no_err", 64'(err_out), 64'd0);
      chk("tear_cam_still_a", 64'(cam_word(k)), 64'h100 + 64'(k));
    end
    frame_pulse();
    chk("tear_commit", 64'(commit_out), 64'd1);
    for (int i = 0; i < NUM_WORDS; i++)
      chk($sformatf("tear_word%0d", i), 64'(cam_word(i)), 64'h200 + 64'(i));
    chk("tear_frames_zero", 64'(frames_since_commit_out), 64'd0);

    // Bad index in mid-stream, then last word shares a cycle with a frame
    for (int i = 0; i < 5; i++) send_word(i, 32'h400 + 32'(i), 1'b0, 1'b0);
    send_word(12, 32'hBAD, 1'b0, 1'b0);
    chk("badidx_err", 64'(err_out), 64'd1);
    chk("badidx_ready", 64'(upd_ready_out), 64'd1);
    for (int i = 5; i < 8; i++) send_word(i, 32'h400 + 32'(i), 1'b0, 1'b0);
    chk("badidx_err_cleared", 64'(err_out), 64'd0);
    send_word(8, 32'h408, 1'b1, 1'b1);
    chk("same_cycle_no_commit", 64'(commit_out), 64'd0);
    chk("same_cycle_pending", 64'(pending_out), 64'd1);
    chk("same_cycle_frames1", 64'(frames_since_commit_out), 64'd1);
    chk("same_cycle_cam_old", 64'(cam_word(0)), 64'h200);
    frame_pulse();
    chk("next_frame_commit", 64'(commit_out), 64'd1);
    chk("next_frame_frames0", 64'(frames_since_commit_out), 64'd0);
    for (int i = 0; i < NUM_WORDS; i++)
      chk($sformatf("badidx_word%0d", i), 64'(cam_word(i)), 64'h400 + 64'(i));

    // Incomplete set: idx 0..7 with last on 7
    for (int i = 0; i < 8; i++) send_word(i, 32'h300 + 32'(i), (i == 7), 1'b0);
    chk("incomplete_err", 64'(err_out), 64'd1);
    chk("incomplete_idle", 64'(pending_out), 64'd0);
    chk("incomplete_ready", 64'(upd_ready_out), 64'd1);
    step();
    chk("incomplete_err_width1", 64'(err_out), 64'd0);
    frame_pulse();
    chk("incomplete_no_commit", 64'(commit_out), 64'd0);
    chk("incomplete_frames1", 64'(frames_since_commit_out), 64'd1);
    chk("incomplete_cam_kept", 64'(cam_word(0)), 64'h400);

    // Mask was cleared: a lone last word on idx 8 must not complete a set
    send_word(8, 32'h999, 1'b1, 1'b0);
    chk("mask_cleared_err", 64'(err_out), 64'd1);
    chk("mask_cleared_idle", 64'(pending_out), 64'd0);

    // Saturation: 300 more frames
    new_frame_in = 1'b1;
    repeat (300) step();
    new_frame_in = 1'b0;
    $display("[TB] 300 frames -> frames=%0d", frames_since_commit_out);
    chk("sat_255", 64'(frames_since_commit_out), 64'd255);
    chk("sat_no_commit", 64'(commit_out), 64'd0);

    // Reset mid-PENDING acts before the next edge
    for (int i = 0; i < NUM_WORDS; i++)
      send_word(i, 32'h500 + 32'(i), (i == NUM_WORDS - 1), 1'b0);
    chk("pre_rst_pending", 64'(pending_out), 64'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    $display("[TB] async reset -> ready=%0b pending=%0b cam_valid=%0b frames=%0d",
             upd_ready_out, pending_out, cam_valid_out, frames_since_commit_out);
    chk("arst_ready", 64'(upd_ready_out), 64'd1);
    chk("arst_pending", 64'(pending_out), 64'd0);
    chk("arst_cam_valid", 64'(cam_valid_out), 64'd0);
    chk("arst_frames", 64'(frames_since_commit_out), 64'd0);
    chk("arst_cam", 64'(cam_out == '0), 64'd1);
    chk("arst_err", 64'(err_out), 64'd0);
    step();
    rst_n_in = 1'b1;
    step();
    chk("post_rst_ready", 64'(upd_ready_out), 64'd1);
    chk("post_rst_pending", 64'(pending_out), 64'd0);
    frame_pulse();
    chk("post_rst_no_commit", 64'(commit_out), 64'd0);
    chk("post_rst_frames1", 64'(frames_since_commit_out), 64'd1);
    chk("post_rst_cam_zero", 64'(cam_out == '0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
